regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised successor to the 8×16 CPU register file. It keeps the dual combinational read, single synchronous write and hardwired-zero r0. It adds three things: a synchronous reset, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. The scoreboard lets the multi-cycle execute path reserve a destination at issue and release it at writeback. It sits between the decoder/issue stage (read addresses, reservations) and the writeback stage (write port), and drives the hazard/stall input of the control FSM.

## Interface
Parameters:
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers (power of two, ≥2); AW = log2(DEPTH)
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes/reservations
- INIT_INDEX, 1, when 1 register i resets to value i (zero-extended); when 0 all registers reset to 0
- BYPASS, 1, when 1 a same-cycle write is forwarded to read ports and clears busy

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- ra_addr  in  AW  read port A address
- rb_addr  in  AW  read port B address
- ra_data  out  WIDTH  read port A data (combinational)
- rb_data  out  WIDTH  read port B data (combinational)
- ra_busy  out  1  register at ra_addr has a pending write
- rb_busy  out  1  register at rb_addr has a pending write
- hazard  out  1  ra_busy | rb_busy
- wr_en  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- rsv_en  in  1  reserve (mark pending) a destination
- rsv_addr  in  AW  register to reserve
- rsv_err  out  1  registered one-cycle pulse: reservation of an already-pending register
- pending_cnt  out  AW+1  number of pending registers (registered)
- dbg_r1  out  WIDTH  contents of register 1 (combinational view)
- dbg_r2  out  WIDTH  contents of register 2 (combinational view)

## Operation
- Storage: DEPTH×WIDTH registers, plus a DEPTH-bit pending vector.
- Reset (rst=1 at a rising edge):
  - registers take their INIT_INDEX value; r0 is always 0;
  - pending vector is cleared; rsv_err=0; pending_cnt=0.
  - rst overrides any concurrent wr_en/rsv_en; the write and the reservation are lost.
- Write: with wr_en=1, reg[wr_addr] ← wr_data and pending[wr_addr] ← 0 at the edge.
  - Writes to r0 are dropped when ZERO_REG=1.
- Reserve: with rsv_en=1, pending[rsv_addr] ← 1 at the edge.
  - Ignored for r0 when ZERO_REG=1.
  - If pending[rsv_addr] was already 1 (and not cleared by a same-cycle write to that address), rsv_err=1 next cycle. The bit stays set.
- Simultaneous write and reserve, same address: the data is written and pending ends at 1, because the new reservation wins. rsv_err=0.
- Simultaneous write and reserve, different addresses: both take effect independently.
- Read: ra_data = reg[ra_addr]; r0 reads 0 when ZERO_REG=1.
  - With BYPASS=1 and wr_en=1 and wr_addr=ra_addr (not r0), ra_data = wr_data in the same cycle.
  - Port B is identical.
- Busy: ra_busy = pending[ra_addr].
  - With BYPASS=1, a same-cycle wr_en to ra_addr forces ra_busy=0.
  - r0 is never busy.
  - Port B is identical.
- pending_cnt is the population count of the pending vector after each edge.

## Timing
- Read data, busy and hazard: zero latency (combinational from addresses, state and, if BYPASS, the write port).
- Write: data is visible on non-bypassed reads the cycle after the edge.
- Reserve: busy is visible the cycle after the edge.
- rsv_err and pending_cnt: registered, updated one cycle after the causing edge.
- Reset values: ra_data/rb_data and dbg_r1/dbg_r2 show the reset contents (1 and 2 with INIT_INDEX=1); all busy/hazard/rsv_err/pending_cnt outputs are 0.
- No handshake stalls inside the block. The issue logic must hold the instruction while hazard=1.

## Test plan
- Reset with defaults, then read ra_addr=5, rb_addr=7: ra_data=5, rb_data=7, dbg_r1=1, dbg_r2=2, hazard=0, pending_cnt=0.
- Write r3←0xBEEF while ra_addr=3:
  - BYPASS=1: ra_data=0xBEEF in the same cycle;
  - BYPASS=0: ra_data=3 in the same cycle, then 0xBEEF next cycle.
- Write r0←0xFFFF, then reserve r0: r0 reads 0, ra_busy=0, pending_cnt=0.
- Reserve r4, then read ra_addr=4: ra_busy=1, hazard=1, pending_cnt=1. Reserve r4 again: rsv_err pulses for one cycle, pending_cnt stays 1. Write r4←0x1234: busy clears (same cycle with BYPASS), pending_cnt=0 next cycle.
- Same cycle, reserve r6 and write r6←0x00AA: next cycle r6=0x00AA, rb_busy(r6)=1, rsv_err=0, pending_cnt=1.
- Reserve r2 and r5, then assert rst together with wr_en r2←0x5555: next cycle r2=2, pending_cnt=0, hazard=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Purpose : DEPTH x WIDTH register file with dual combinational read, one synchronous
//           write, optional hardwired-zero r0, same-cycle write bypass and a per-register
//           pending-write scoreboard (reserve at issue, release at writeback).
// Latency : reads/busy/hazard are combinational; write and reserve take effect at the
//           next rising edge; rsv_err and pending_cnt are registered (one cycle after).
// Backpr. : none inside the block; issue logic must hold while hazard=1.
// Ports   : clk/rst (sync, active-high); ra_*/rb_* read ports with data and busy;
//           hazard = ra_busy|rb_busy; wr_* write port; rsv_* reservation port with
//           rsv_err pulse; pending_cnt popcount; dbg_r1/dbg_r2 raw views of r1/r2.
module regfile_sb #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 8,
   parameter int ZERO_REG   = 1,
   parameter int INIT_INDEX = 1,
   parameter int BYPASS     = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    ra_addr,
   input  logic [AW-1:0]    rb_addr,
   output logic [WIDTH-1:0] ra_data,
   output logic [WIDTH-1:0] rb_data,
   output logic             ra_busy,
   output logic             rb_busy,
   output logic             hazard,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rsv_en,
   input  logic [AW-1:0]    rsv_addr,
   output logic             rsv_err,
   output logic [AW:0]      pending_cnt,
   output logic [WIDTH-1:0] dbg_r1,
   output logic [WIDTH-1:0] dbg_r2
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] pending_q, pending_d;
   logic             rsv_err_q, rsv_err_d;
   logic [AW:0]      pending_cnt_q, pending_cnt_d;

   // Effective write/reserve: accesses to a hardwired r0 are discarded up front so
   // neither the storage, the scoreboard nor the bypass ever sees them.
   logic wr_eff, rsv_eff;
   assign wr_eff  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
   assign rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

   always_comb begin
      regs_d        = regs_q;
      pending_d     = pending_q;
      pending_cnt_d = '0;
      if (wr_eff) begin
         regs_d[wr_addr]    = wr_data;
         pending_d[wr_addr] = 1'b0;
      end
      // Reservation is applied after the write so a same-address pair leaves the
      // register pending: the new in-flight producer owns the destination.
      if (rsv_eff) begin
         pending_d[rsv_addr] = 1'b1;
      end
      // A double reservation is only an error if the bit is not being released by a
      // writeback in the same cycle.
      rsv_err_d = rsv_eff && pending_q[rsv_addr] && !(wr_eff && (wr_addr == rsv_addr));
      for (int i = 0; i < DEPTH; i++) begin
         pending_cnt_d = pending_cnt_d + (AW+1)'(pending_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= (INIT_INDEX != 0) ? WIDTH'(i) : '0;
         end
         pending_q     <= '0;
         rsv_err_q     <= 1'b0;
         pending_cnt_q <= '0;
      end else begin
         regs_q        <= regs_d;
         pending_q     <= pending_d;
         rsv_err_q     <= rsv_err_d;
         pending_cnt_q <= pending_cnt_d;
      end
   end

   // Read ports: zero register first, then same-cycle bypass, then storage.
   logic zero_a, zero_b, byp_a, byp_b;
   assign zero_a = (ZERO_REG != 0) && (ra_addr == '0);
   assign zero_b = (ZERO_REG != 0) && (rb_addr == '0);
   assign byp_a  = (BYPASS != 0) && wr_eff && (wr_addr == ra_addr);
   assign byp_b  = (BYPASS != 0) && wr_eff && (wr_addr == rb_addr);

   assign ra_data = zero_a ? '0 : (byp_a ? wr_data : regs_q[ra_addr]);
   assign rb_data = zero_b ? '0 : (byp_b ? wr_data : regs_q[rb_addr]);

   // A bypassed write is the release of the reservation, so the consumer may proceed.
   assign ra_busy = !zero_a && !byp_a && pending_q[ra_addr];
   assign rb_busy = !zero_b && !byp_b && pending_q[rb_addr];
   assign hazard  = ra_busy | rb_busy;

   assign rsv_err     = rsv_err_q;
   assign pending_cnt = pending_cnt_q;

   // Debug views show committed storage only, never the bypass path.
   assign dbg_r1 = regs_q[1];
   generate
      if (DEPTH > 2) begin : g_dbg_r2
         assign dbg_r2 = regs_q[2];
      end else begin : g_no_r2
         assign dbg_r2 = '0;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Purpose : self-checking bench for regfile_sb (default params plus a BYPASS=0 copy).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the
//           falling edge of the same cycle.
// Backpr. : none.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [2:0]  ra_addr, rb_addr, wr_addr, rsv_addr;
   logic [15:0] ra_data, rb_data, wr_data, dbg_r1, dbg_r2;
   logic        ra_busy, rb_busy, hazard, wr_en, rsv_en, rsv_err;
   logic [3:0]  pending_cnt;

   logic        nb_rst;
   logic [2:0]  nb_ra_addr, nb_rb_addr, nb_wr_addr, nb_rsv_addr;
   logic [15:0] nb_ra_data, nb_rb_data, nb_wr_data, nb_dbg_r1, nb_dbg_r2;
   logic        nb_ra_busy, nb_rb_busy, nb_hazard, nb_wr_en, nb_rsv_en, nb_rsv_err;
   logic [3:0]  nb_pending_cnt;

   int checks   = 0;
   int failures = 0;

   regfile_sb dut (
      .clk(clk), .rst(rst),
      .ra_addr(ra_addr), .rb_addr(rb_addr),
      .ra_data(ra_data), .rb_data(rb_data),
      .ra_busy(ra_busy), .rb_busy(rb_busy), .hazard(hazard),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(rsv_err),
      .pending_cnt(pending_cnt), .dbg_r1(dbg_r1), .dbg_r2(dbg_r2)
   );

   regfile_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(nb_rst),
      .ra_addr(nb_ra_addr), .rb_addr(nb_rb_addr),
      .ra_data(nb_ra_data), .rb_data(nb_rb_data),
      .ra_busy(nb_ra_busy), .rb_busy(nb_rb_busy), .hazard(nb_hazard),
      .wr_en(nb_wr_en), .wr_addr(nb_wr_addr), .wr_data(nb_wr_data),
      .rsv_en(nb_rsv_en), .rsv_addr(nb_rsv_addr), .rsv_err(nb_rsv_err),
      .pending_cnt(nb_pending_cnt), .dbg_r1(nb_dbg_r1), .dbg_r2(nb_dbg_r2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        chk;
      logic        rst;
      logic [2:0]  ra, rb;
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        re;
      logic [2:0]  rsa;
      logic [15:0] e_ra, e_rb;
      logic        e_rab, e_rbb, e_hz, e_err;
      logic [3:0]  e_cnt;
      logic [15:0] e_d1, e_d2;
   } vec_t;

   vec_t vecs[$];
   vec_t sb_q[$];

   function automatic vec_t mk(
      input logic chk, input logic r, input logic [2:0] ra, input logic [2:0] rb,
      input logic we, input logic [2:0] wa, input logic [15:0] wd,
      input logic re, input logic [2:0] rsa,
      input logic [15:0] e_ra, input logic [15:0] e_rb,
      input logic e_rab, input logic e_rbb, input logic e_hz, input logic e_err,
      input logic [3:0] e_cnt, input logic [15:0] e_d1, input logic [15:0] e_d2);
      vec_t v;
      v.chk = chk; v.rst = r; v.ra = ra; v.rb = rb;
      v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.rsa = rsa;
      v.e_ra = e_ra; v.e_rb = e_rb; v.e_rab = e_rab; v.e_rbb = e_rbb;
      v.e_hz = e_hz; v.e_err = e_err; v.e_cnt = e_cnt; v.e_d1 = e_d1; v.e_d2 = e_d2;
      return v;
   endfunction

   task automatic compare(input string nm, input int idx, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
      end
   endtask

   initial begin
      vec_t e;
      rst = 1'b0; ra_addr = '0; rb_addr = '0; wr_en = 1'b0; wr_addr = '0;
      wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
      nb_rst = 1'b0; nb_ra_addr = '0; nb_rb_addr = '0; nb_wr_en = 1'b0; nb_wr_addr = '0;
      nb_wr_data = '0; nb_rsv_en = 1'b0; nb_rsv_addr = '0;

      //                 chk rst ra rb we wa wd       re rsa  e_ra     e_rb     rab rbb hz err cnt d1       d2
      vecs.push_back(mk(0, 1, 5, 7, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
      vecs.push_back(mk(1, 0, 5, 7, 0, 0, 16'h0000, 0, 0, 16'h0005, 16'h0007, 0, 0, 0, 0, 0, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 3, 7, 1, 3, 16'hBEEF, 0, 0, 16'hBEEF, 16'h0007, 0, 0, 0, 0, 0, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 3, 0, 1, 0, 16'hFFFF, 0, 0, 16'hBEEF, 16'h0000, 0, 0, 0, 0, 0, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 0, 3, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 0, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 0, 4, 0, 0, 16'h0000, 1, 4, 16'h0000, 16'h0004, 0, 0, 0, 0, 0, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 4, 0, 0, 0, 16'h0000, 1, 4, 16'h0004, 16'h0000, 1, 0, 1, 0, 1, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 4, 0, 1, 4, 16'h1234, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 1, 1, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 4, 6, 1, 6, 16'h00AA, 1, 6, 16'h1234, 16'h00AA, 0, 0, 0, 0, 0, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 1, 6, 0, 0, 16'h0000, 0, 0, 16'h0001, 16'h00AA, 0, 1, 1, 0, 1, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 2, 5, 0, 0, 16'h0000, 1, 2, 16'h0002, 16'h0005, 0, 0, 0, 0, 1, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 2, 5, 0, 0, 16'h0000, 1, 5, 16'h0002, 16'h0005, 1, 0, 1, 0, 2, 16'h0001, 16'h0002));
      vecs.push_back(mk(0, 1, 2, 5, 1, 2, 16'h5555, 1, 3, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
      vecs.push_back(mk(1, 0, 2, 5, 0, 0, 16'h0000, 0, 0, 16'h0002, 16'h0005, 0, 0, 0, 0, 0, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 3, 6, 0, 0, 16'h0000, 1, 3, 16'h0003, 16'h0006, 0, 0, 0, 0, 0, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 3, 6, 1, 3, 16'h0042, 1, 3, 16'h0042, 16'h0006, 0, 0, 0, 0, 1, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 3, 6, 0, 0, 16'h0000, 0, 0, 16'h0042, 16'h0006, 1, 0, 1, 0, 1, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 1, 3, 1, 1, 16'h7777, 0, 0, 16'h7777, 16'h0042, 0, 1, 1, 0, 1, 16'h0001, 16'h0002));
      vecs.push_back(mk(1, 0, 1, 2, 0, 0, 16'h0000, 0, 0, 16'h7777, 16'h0002, 0, 0, 0, 0, 1, 16'h7777, 16'h0002));

      foreach (vecs[k]) begin
         @(posedge clk);
         #1;
         rst = vecs[k].rst; ra_addr = vecs[k].ra; rb_addr = vecs[k].rb;
         wr_en = vecs[k].we; wr_addr = vecs[k].wa; wr_data = vecs[k].wd;
         rsv_en = vecs[k].re; rsv_addr = vecs[k].rsa;
         if (vecs[k].chk) sb_q.push_back(vecs[k]);
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            compare("ra_data", k, 32'(ra_data), 32'(e.e_ra));
            compare("rb_data", k, 32'(rb_data), 32'(e.e_rb));
            compare("ra_busy", k, 32'(ra_busy), 32'(e.e_rab));
            compare("rb_busy", k, 32'(rb_busy), 32'(e.e_rbb));
            compare("hazard", k, 32'(hazard), 32'(e.e_hz));
            compare("rsv_err", k, 32'(rsv_err), 32'(e.e_err));
            compare("pending_cnt", k, 32'(pending_cnt), 32'(e.e_cnt));
            compare("dbg_r1", k, 32'(dbg_r1), 32'(e.e_d1));
            compare("dbg_r2", k, 32'(dbg_r2), 32'(e.e_d2));
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;

      // BYPASS=0 instance: writes and releases only become visible after the edge.
      nb_rst = 1'b1;
      @(posedge clk);
      #1;
      nb_rst = 1'b0; nb_ra_addr = 3'd3; nb_rb_addr = 3'd7;
      nb_wr_en = 1'b1; nb_wr_addr = 3'd3; nb_wr_data = 16'hBEEF;
      @(negedge clk);
      compare("nb_ra_data_same_cycle", 100, 32'(nb_ra_data), 32'h0003);
      compare("nb_rb_data_reset", 100, 32'(nb_rb_data), 32'h0007);
      @(posedge clk);
      #1;
      nb_wr_en = 1'b0;
      @(negedge clk);
      compare("nb_ra_data_next_cycle", 101, 32'(nb_ra_data), 32'hBEEF);
      @(posedge clk);
      #1;
      nb_ra_addr = 3'd4; nb_rsv_en = 1'b1; nb_rsv_addr = 3'd4;
      @(negedge clk);
      compare("nb_ra_busy_before_rsv", 102, 32'(nb_ra_busy), 32'h0);
      @(posedge clk);
      #1;
      nb_rsv_en = 1'b0; nb_wr_en = 1'b1; nb_wr_addr = 3'd4; nb_wr_data = 16'h1234;
      @(negedge clk);
      compare("nb_ra_busy_during_wr", 103, 32'(nb_ra_busy), 32'h1);
      compare("nb_hazard_during_wr", 103, 32'(nb_hazard), 32'h1);
      compare("nb_ra_data_during_wr", 103, 32'(nb_ra_data), 32'h0004);
      compare("nb_pending_cnt", 103, 32'(nb_pending_cnt), 32'h1);
      @(posedge clk);
      #1;
      nb_wr_en = 1'b0;
      @(negedge clk);
      compare("nb_ra_busy_after_wr", 104, 32'(nb_ra_busy), 32'h0);
      compare("nb_ra_data_after_wr", 104, 32'(nb_ra_data), 32'h1234);
      compare("nb_pending_cnt_after", 104, 32'(nb_pending_cnt), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
